// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq handshake bundle: start/operand in, busy/done/result out.
// ovf exists only when BIN2BCD_OVF_EN is defined.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_OVF_EN
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );
  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
`else
  modport master (
    output start, bin_in,
    input  busy, done, bcd_out
  );
  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out
  );
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional BIN2BCD_OVF_EN adds a sticky overflow flag for the top digit.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic clk,
  input  logic rst,
  bin2bcd_seq_if.slave bus
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [DW-1:0]       bcd_q, bcd_d;
  logic [DW-1:0]       adj;
  logic [DW+BIN_W-1:0] shifted;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;
`ifdef BIN2BCD_OVF_EN
  logic                carry;
  logic                acc_q, acc_d;
  logic                ovf_q, ovf_d;
`endif

  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] > 4'd4) begin
        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // top bit of adj falls off here: value is kept mod 10^DIGITS
  assign shifted = {adj, bin_q} << 1;
`ifdef BIN2BCD_OVF_EN
  assign carry = adj[DW-1];
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    dig_d   = dig_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef BIN2BCD_OVF_EN
    acc_d   = acc_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          bin_d   = bus.bin_in;
          dig_d   = '0;
          cnt_d   = CW'(BIN_W);
`ifdef BIN2BCD_OVF_EN
          acc_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        bin_d = shifted[BIN_W-1:0];
        dig_d = shifted[BIN_W +: DW];
        cnt_d = cnt_q - CW'(1);
`ifdef BIN2BCD_OVF_EN
        acc_d = acc_q | carry;
`endif
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = shifted[BIN_W +: DW];
`ifdef BIN2BCD_OVF_EN
          ovf_d   = acc_q | carry;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_OVF_EN
      acc_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      dig_q   <= dig_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef BIN2BCD_OVF_EN
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
`ifdef BIN2BCD_OVF_EN
  assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 3-digit and 2-digit (truncating) instances.
// Overflow checks are compiled in with BIN2BCD_OVF_EN.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) b3 ();
  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b2 ();

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_d3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_d2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start3(input logic [7:0] v);
    b3.start  = 1'b1;
    b3.bin_in = v;
    tick();
    b3.start  = 1'b0;
    b3.bin_in = ~v;
  endtask

  task automatic start2(input logic [7:0] v);
    b2.start  = 1'b1;
    b2.bin_in = v;
    tick();
    b2.start  = 1'b0;
    b2.bin_in = ~v;
  endtask

  task automatic wait3(output int cyc, output int nb);
    cyc = 0;
    nb  = 0;
    while (b3.done !== 1'b1 && cyc < 20) begin
      if (b3.busy === 1'b1) nb++;
      tick();
      cyc++;
    end
  endtask

  task automatic wait2(output int cyc);
    cyc = 0;
    while (b2.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic watch3(input int n, output int nd);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (b3.done === 1'b1) nd++;
    end
  endtask

  logic [7:0] v2_in  [5] = '{8'd150, 8'd42, 8'd99, 8'd100, 8'd0};
  logic [7:0] v2_bcd [5] = '{8'h50, 8'h42, 8'h99, 8'h00, 8'h00};
  logic       v2_ovf [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int cyc;
    int nb;
    int nd;
    rst       = 1'b1;
    b3.start  = 1'b0;
    b3.bin_in = '0;
    b2.start  = 1'b0;
    b2.bin_in = '0;
    repeat (2) tick();
    rst = 1'b0;

    chk("rst_busy", 32'(b3.busy), 32'd0);
    chk("rst_done", 32'(b3.done), 32'd0);
    chk("rst_bcd", 32'(b3.bcd_out), 32'h000);
    chk("rst_bcd2", 32'(b2.bcd_out), 32'h00);
`ifdef BIN2BCD_OVF_EN
    chk("rst_ovf", 32'(b3.ovf), 32'd0);
`endif

    start3(8'd255);
    wait3(cyc, nb);
    chk("255_lat", 32'(cyc), 32'd8);
    chk("255_busy_cycles", 32'(nb), 32'd8);
    chk("255_busy_end", 32'(b3.busy), 32'd0);
    chk("255_bcd", 32'(b3.bcd_out), 32'h255);
`ifdef BIN2BCD_OVF_EN
    chk("255_ovf", 32'(b3.ovf), 32'd0);
`endif
    tick();
    chk("255_done_clr", 32'(b3.done), 32'd0);
    chk("255_hold", 32'(b3.bcd_out), 32'h255);

    start3(8'd0);
    wait3(cyc, nb);
    chk("b2b0_lat", 32'(cyc), 32'd8);
    chk("b2b0_bcd", 32'(b3.bcd_out), 32'h000);
    start3(8'd99);
    chk("b2b99_busy", 32'(b3.busy), 32'd1);
    wait3(cyc, nb);
    chk("b2b99_lat", 32'(cyc), 32'd8);
    chk("b2b99_bcd", 32'(b3.bcd_out), 32'h099);
    start3(8'd200);
    wait3(cyc, nb);
    chk("b2b200_lat", 32'(cyc), 32'd8);
    chk("b2b200_bcd", 32'(b3.bcd_out), 32'h200);

    start3(8'd37);
    tick();
    tick();
    b3.start  = 1'b1;
    b3.bin_in = 8'd50;
    tick();
    b3.start  = 1'b0;
    wait3(cyc, nb);
    chk("ign_lat", 32'(cyc), 32'd5);
    chk("ign_bcd", 32'(b3.bcd_out), 32'h037);
    watch3(12, nd);
    chk("ign_no_done", 32'(nd), 32'd0);
    chk("ign_idle", 32'(b3.busy), 32'd0);
    chk("ign_hold", 32'(b3.bcd_out), 32'h037);

    start3(8'd128);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(b3.busy), 32'd0);
    chk("abort_done", 32'(b3.done), 32'd0);
    chk("abort_bcd", 32'(b3.bcd_out), 32'h000);
    watch3(12, nd);
    chk("abort_no_done", 32'(nd), 32'd0);
    start3(8'd9);
    wait3(cyc, nb);
    chk("after_abort_lat", 32'(cyc), 32'd8);
    chk("after_abort_bcd", 32'(b3.bcd_out), 32'h009);

    for (int i = 0; i < 5; i++) begin
      start2(v2_in[i]);
      wait2(cyc);
      chk($sformatf("d2_lat_%0d", v2_in[i]), 32'(cyc), 32'd8);
      chk($sformatf("d2_bcd_%0d", v2_in[i]), 32'(b2.bcd_out),
          32'(v2_bcd[i]));
`ifdef BIN2BCD_OVF_EN
      chk($sformatf("d2_ovf_%0d", v2_in[i]), 32'(b2.ovf),
          32'(v2_ovf[i]));
`else
      if (v2_ovf[i]) chk("d2_trunc_busy", 32'(b2.busy), 32'd0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
